// File: rtl/addmul_pkg.sv
// Shared types and the combine operation for the add-multiply pipeline.
// The design and the testbench reference model both use this package.
package addmul_pkg;

  typedef enum logic [1:0] {
    OP_OR  = 2'd0,
    OP_AND = 2'd1,
    OP_XOR = 2'd2,
    OP_ADD = 2'd3
  } op_e;

  localparam int MAX_WIDTH = 24;
  localparam int WIDE_W    = 2*MAX_WIDTH+1;

  typedef logic [WIDE_W-1:0] wide_t;

  // Callers pass operands already extended and keep only the low 2*WIDTH+1 bits,
  // so the ADD carry beyond that width is discarded by the caller.
  function automatic wide_t combine(input op_e op, input wide_t p, input wide_t c);
    wide_t r;
    case (op)
      OP_OR:   r = p | c;
      OP_AND:  r = p & c;
      OP_XOR:  r = p ^ c;
      default: r = p + c;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/addmul_pipe_if.sv
// Operand, control and result bundle for addmul_pipe.
// The driver of operands uses master; the pipeline itself uses slave.
interface addmul_pipe_if #(
  parameter int WIDTH     = 9,
  parameter int OUT_WIDTH = 2*WIDTH
);
  import addmul_pkg::*;

  logic                 ce;
  logic                 in_valid;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [WIDTH-1:0]     c;
  logic [WIDTH-1:0]     d;
  op_e                  op;
  logic [OUT_WIDTH-1:0] out;
  logic                 out_valid;
  logic                 busy;

  modport master (
    output ce, in_valid, a, b, c, d, op,
    input  out, out_valid, busy
  );

  modport slave (
    input  ce, in_valid, a, b, c, d, op,
    output out, out_valid, busy
  );

endinterface

// File: rtl/addmul_pipe_reg.sv
// One pipeline stage: a data word plus its valid bit, advancing only on ce.
// Reset clears both, so the last stage presents zero right after reset.
module pipe_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (ce) begin
      r_valid <= i_valid;
      r_data  <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/addmul_pipe.sv
// Computes ((d + a) * b) OP c and carries it through STAGES registered stages.
// The full 2*WIDTH+1 bit result is pipelined; truncation happens at the output only.
module addmul_pipe
  import addmul_pkg::*;
#(
  parameter int WIDTH     = 9,
  parameter int OUT_WIDTH = 2*WIDTH,
  parameter int STAGES    = 3,
  parameter bit SIGNED    = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  addmul_pipe_if.slave bus
);

  localparam int PW = 2*WIDTH+1;

  logic [WIDTH:0]  w_aExt;
  logic [WIDTH:0]  w_dExt;
  logic [WIDTH:0]  w_sum;
  logic [PW-1:0]   w_sumExt;
  logic [PW-1:0]   w_bExt;
  logic [PW-1:0]   w_cExt;
  logic [PW-1:0]   w_prod;
  logic [PW-1:0]   w_comb;
  logic [STAGES:0] w_valid;
  logic [PW-1:0]   w_data [0:STAGES];

  // The extension bit is the operand MSB only in signed mode, so the sum never overflows.
  assign w_aExt   = {SIGNED & bus.a[WIDTH-1], bus.a};
  assign w_dExt   = {SIGNED & bus.d[WIDTH-1], bus.d};
  assign w_sum    = w_aExt + w_dExt;
  assign w_sumExt = {{WIDTH{SIGNED & w_sum[WIDTH]}}, w_sum};
  assign w_bExt   = {{(WIDTH+1){SIGNED & bus.b[WIDTH-1]}}, bus.b};
  assign w_cExt   = {{(WIDTH+1){SIGNED & bus.c[WIDTH-1]}}, bus.c};
  assign w_prod   = w_sumExt * w_bExt;
  assign w_comb   = PW'(combine(bus.op, wide_t'(w_prod), wide_t'(w_cExt)));

  assign w_valid[0] = bus.in_valid;
  assign w_data[0]  = w_comb;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    pipe_reg #(
      .DATA_W (PW)
    ) u_reg (
      .clk     (clk),
      .rst     (rst),
      .ce      (bus.ce),
      .i_valid (w_valid[s]),
      .i_data  (w_data[s]),
      .o_valid (w_valid[s+1]),
      .o_data  (w_data[s+1])
    );
  end

  assign bus.out       = OUT_WIDTH'(w_data[STAGES]);
  assign bus.out_valid = w_valid[STAGES];
  assign bus.busy      = |w_valid[STAGES:1];

endmodule

// File: doc/addmul_pipe.md
ADDMUL_PIPE -- requirements
Module: addmul_pipe

Interface
REQ-001 Parameter WIDTH, default 9, operand width of a, b, c, d (legal 2..24).
REQ-002 Parameter OUT_WIDTH, default 2*WIDTH, result width (legal 1..2*WIDTH+1).
REQ-003 Parameter STAGES, default 3, pipeline register depth in cycles (legal 1..8).
REQ-004 Parameter SIGNED, default 0, operand interpretation: 0 = unsigned, 1 = two's complement.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 ce  input  1  pipeline advance enable; low = whole pipeline holds.
REQ-008 in_valid  input  1  operands on a/b/c/d/op are a valid transaction.
REQ-009 a, b, c, d  input  WIDTH each  operands.
REQ-010 op  input  2  combine mode: 0 OR, 1 AND, 2 XOR, 3 ADD.
REQ-011 out  output  OUT_WIDTH  result of the transaction leaving the last stage.
REQ-012 out_valid  output  1  out holds a valid result.
REQ-013 busy  output  1  at least one valid transaction is in flight in any stage.

Function
REQ-014 The result SHALL be R = (((d + a) * b) OPc) mod 2^OUT_WIDTH, where OPc is the op-selected combine with c.
REQ-015 The sum d + a SHALL be formed at WIDTH+1 bits and the product at 2*WIDTH+1 bits, both without overflow; a, b, d SHALL be sign-extended when SIGNED=1 and zero-extended otherwise.
REQ-016 c SHALL be extended to 2*WIDTH+1 bits using the same SIGNED rule before the combine; ADD wraps modulo 2^(2*WIDTH+1); truncation to OUT_WIDTH SHALL happen only at the output.
REQ-017 With ce held high, a transaction sampled at edge N SHALL appear on out/out_valid after edge N+STAGES-1; that is, it is registered through STAGES flops, and out is the output of the last flop.
REQ-018 Each stage SHALL carry a valid bit alongside its data; out_valid SHALL be the valid bit of the last stage.
REQ-019 When ce is low, all data and valid registers SHALL hold, and in_valid/operands SHALL be ignored that cycle.
REQ-020 When ce is high and in_valid is low, a bubble (valid=0) SHALL enter stage 0; data registers for a bubble MAY update but out SHALL be ignored when out_valid=0.
REQ-021 Back-to-back transactions (in_valid high every ce cycle) SHALL give one result per cycle, in order, with no loss; initiation interval SHALL be 1.
REQ-022 busy SHALL be the OR of all stage valid bits (registered values, not in_valid).
REQ-023 Placement of the arithmetic among the stages is implementation-defined; only the end-to-end latency and result are architectural.

Reset
REQ-024 On rst high at a clock edge, all valid bits SHALL clear to 0, and out SHALL be driven to 0 from the next cycle; out_valid=0 and busy=0.
REQ-025 rst SHALL take priority over ce; in-flight transactions are discarded, and none reappear after rst deasserts.
REQ-026 A transaction presented in the cycle rst is high SHALL be dropped.

Structure
REQ-027 A shared package addmul_pkg SHALL hold the op_e enum (OP_OR, OP_AND, OP_XOR, OP_ADD) and a combine function used by RTL and bench model.
REQ-028 One sub-module, pipe_reg (parametrised data width, with valid, ce and rst), SHALL be instantiated STAGES times via generate.

Verification
REQ-029 WIDTH=9, STAGES=3, SIGNED=0, OUT_WIDTH=18: a=5, d=3, b=4, c=1, op=OR, single pulse -> out=33, with out_valid high for exactly one cycle, 3 cycles after sampling.
REQ-030 Same config, a=d=b=511, c=0, op=OR -> out=0x3F802 (truncation); op=ADD with c=1 -> out=0x3F803.
REQ-031 SIGNED=1, same widths: a=0x1FF (-1), d=0x1FE (-2), b=3, c=0, op=XOR -> out=0x3FFF7 (-9).
REQ-032 Stream of 10 back-to-back transactions, ce low for 2 cycles mid-stream -> all 10 results in order, and out/out_valid frozen during the stall; latency is extended by exactly 2.
REQ-033 rst asserted while 3 transactions are in flight -> out_valid=0, out=0, busy=0 the next cycle; no stale result after release.
REQ-034 STAGES=1 and STAGES=8 random regression against the package model -> zero mismatches over 10k transactions.
